// File: rtl/alu_iter_exec_if.sv
// Handshake/payload bundle between the ID/EX register and the iterative ALU execute stage.
interface alu_iter_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport slave (
    input  flush_i, valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
    output ready_o, out_valid_o, result_o, zero_o
  );

  modport master (
    output flush_i, valid_i, ALUCtrl_i, data1_i, data2_i, out_ready_i,
    input  ready_o, out_valid_o, result_o, zero_o
  );
endinterface

// File: rtl/alu_iter_exec.sv
// ALU execute stage: single-cycle logic/arith ops, iterative shift-add MUL,
// valid/ready on both sides, registered result and zero flag.
module alu_iter_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_iter_exec_if.slave   bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SRAI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic             r_out_valid;
  logic             r_zero;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [SHW-1:0]   r_cnt;

  logic             w_zero_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mcand_nxt;
  logic [WIDTH-1:0] w_mplier_nxt;
  logic [SHW-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_acc_step;
  logic [SHW-1:0]   w_shamt;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;

  assign w_shamt    = bus.data2_i[SHW-1:0];
  assign w_accept   = (r_state == S_IDLE) && bus.valid_i && !bus.flush_i;
  assign w_is_mul   = (bus.ALUCtrl_i == OP_MUL);
  assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle operations; MUL and undefined codes yield 0 here.
  always_comb begin
    w_alu = '0;
    case (bus.ALUCtrl_i)
      OP_AND:                        w_alu = bus.data1_i & bus.data2_i;
      OP_XOR:                        w_alu = bus.data1_i ^ bus.data2_i;
      OP_SLL:                        w_alu = bus.data1_i << w_shamt;
      OP_ADD, OP_ADDI, OP_LW, OP_SW: w_alu = bus.data1_i + bus.data2_i;
      OP_SUB, OP_BEQ:                w_alu = bus.data1_i - bus.data2_i;
      OP_SRAI:                       w_alu = WIDTH'($signed(bus.data1_i) >>> w_shamt);
      default:                       w_alu = '0;
    endcase
  end

  // Next state; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.valid_i) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      S_MUL:  if (w_mul_last)  w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) w_state_nxt = S_IDLE;
  end

  // Datapath next values; result/zero only move when DONE is entered.
  always_comb begin
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    if (w_accept) begin
      if (w_is_mul) begin
        w_acc_nxt    = '0;
        w_mcand_nxt  = bus.data1_i;
        w_mplier_nxt = bus.data2_i;
        w_cnt_nxt    = '0;
      end else begin
        w_result_nxt = w_alu;
        w_zero_nxt   = (w_alu == '0);
      end
    end else if ((r_state == S_MUL) && !bus.flush_i) begin
      w_acc_nxt    = w_acc_step;
      w_mcand_nxt  = r_mcand << 1;
      w_mplier_nxt = r_mplier >> 1;
      w_cnt_nxt    = r_cnt + SHW'(1);
      if (w_mul_last) begin
        w_result_nxt = w_acc_step;
        w_zero_nxt   = (w_acc_step == '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_result    <= w_result_nxt;
      r_zero      <= w_zero_nxt;
      r_acc       <= w_acc_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.ready_o     = r_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.result_o    = r_result;
  assign bus.zero_o      = r_zero;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed literal cases plus randomized ops
// against a transaction-level model, with every-cycle output comparison.
module tb_alu_iter_exec;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_iter_exec_if #(.WIDTH(W)) bus();

  alu_iter_exec #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic        chk_en   = 1'b0;
  logic        exp_ready;
  logic        exp_ov;
  logic        exp_zero;
  logic [31:0] exp_res;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endfunction

  // Reference semantics of each control code.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [63:0] p;
    logic [31:0] ones;
    s    = b % 32;
    ones = 32'hFFFF_FFFF;
    case (c)
      4'd0:                   return a & b;
      4'd1:                   return a ^ b;
      4'd2:                   return a << s;
      4'd3, 4'd6, 4'd8, 4'd9: return a + b;
      4'd4, 4'd10:            return a - b;
      4'd5: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      4'd7:                   return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
      default:                return 32'h0;
    endcase
  endfunction

  // Compare process: outputs must match expectations on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o",     32'(bus.ready_o),     32'(exp_ready));
      check("out_valid_o", 32'(bus.out_valid_o), 32'(exp_ov));
      check("result_o",    bus.result_o,         exp_res);
      check("zero_o",      32'(bus.zero_o),      32'(exp_zero));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. DONE is entered d edges after the accept edge (0 for single-cycle,
  // W for MUL); DONE is held for 'hold' extra cycles; flush_k >= 0 flushes before that edge.
  task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int flush_k, input bit noise);
    logic [31:0] r;
    int d;
    r = ref_alu(code, a, b);
    d = (code == 4'd5) ? int'(W) : 0;
    for (int k = 0; k <= d + hold + 1; k++) begin
      if (k == 0) begin
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = code;
        bus.data1_i   = a;
        bus.data2_i   = b;
      end else begin
        bus.valid_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ALUCtrl_i = 4'($urandom_range(0, 15));
        bus.data1_i   = $urandom;
        bus.data2_i   = $urandom;
      end
      if (k == d + hold + 1) bus.out_ready_i = 1'b1;
      else if (k <= d)       bus.out_ready_i = 1'($urandom_range(0, 1));
      else                   bus.out_ready_i = 1'b0;
      bus.flush_i = (k == flush_k);
      step();
      if (k == flush_k) begin
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        exp_ready   = 1'b1;
        exp_ov      = 1'b0;
        return;
      end
      if (k < d) begin
        exp_ready = 1'b0;
        exp_ov    = 1'b0;
      end else if (k <= d + hold) begin
        exp_ready = 1'b0;
        exp_ov    = 1'b1;
        exp_res   = r;
        exp_zero  = (r == 32'h0);
      end else begin
        exp_ready = 1'b1;
        exp_ov    = 1'b0;
      end
    end
    bus.valid_i     = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic set_reset_exp();
    exp_ready = 1'b1;
    exp_ov    = 1'b0;
    exp_res   = 32'h0;
    exp_zero  = 1'b0;
  endtask

  task automatic check_reset_now(input string tag);
    check({tag, "_ready"},  32'(bus.ready_o),     32'd1);
    check({tag, "_ovalid"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_result"}, bus.result_o,         32'd0);
    check({tag, "_zero"},   32'(bus.zero_o),      32'd0);
  endtask

  // Reset asserted between edges while a MUL is iterating.
  task automatic reset_mid_mul();
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 4'd5;
    bus.data1_i   = 32'h1234_5678;
    bus.data2_i   = 32'h0000_00FF;
    step();
    bus.valid_i = 1'b0;
    exp_ready   = 1'b0;
    exp_ov      = 1'b0;
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    set_reset_exp();
    #1;
    check_reset_now("rst_mid_mul");
    step();
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    int          d;
    int          fk;

    bus.flush_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.ALUCtrl_i   = 4'h0;
    bus.data1_i     = 32'h0;
    bus.data2_i     = 32'h0;
    bus.out_ready_i = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    set_reset_exp();
    #1;
    check_reset_now("por");
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    run_op(4'd3, 32'd5, 32'd7, 0, -1, 1'b0);
    check("lit_add", bus.result_o, 32'd12);
    check("lit_add_zero", 32'(bus.zero_o), 32'd0);
    run_op(4'd4, 32'd3, 32'd5, 0, -1, 1'b1);
    check("lit_sub", bus.result_o, 32'hFFFF_FFFE);
    run_op(4'd10, 32'd9, 32'd9, 0, -1, 1'b0);
    check("lit_beq", bus.result_o, 32'h0);
    check("lit_beq_zero", 32'(bus.zero_o), 32'd1);
    run_op(4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 0, -1, 1'b0);
    check("lit_undef", bus.result_o, 32'h0);
    check("lit_undef_zero", 32'(bus.zero_o), 32'd1);
    run_op(4'd7, 32'h8000_0000, 32'h0000_0024, 0, -1, 1'b0);
    check("lit_srai", bus.result_o, 32'hF800_0000);
    run_op(4'd2, 32'd1, 32'd31, 0, -1, 1'b0);
    check("lit_sll", bus.result_o, 32'h8000_0000);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd3, 0, -1, 1'b1);
    check("lit_mul", bus.result_o, 32'hFFFF_FFFD);
    run_op(4'd5, 32'h0001_0000, 32'h0001_0000, 0, -1, 1'b0);
    check("lit_mul_wrap", bus.result_o, 32'h0);
    check("lit_mul_wrap_zero", 32'(bus.zero_o), 32'd1);
    run_op(4'd3, 32'd1, 32'd2, 10, -1, 1'b1);
    check("lit_backpressure", bus.result_o, 32'd3);
    run_op(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, -1, 1'b0);
    check("lit_and", bus.result_o, 32'hF000_F000);
    run_op(4'd5, 32'd6, 32'd7, 0, 10, 1'b0);
    check("lit_flush_keep", bus.result_o, 32'hF000_F000);
    run_op(4'd3, 32'd4, 32'd4, 0, 0, 1'b0);
    check("lit_flush_idle", bus.result_o, 32'hF000_F000);
    reset_mid_mul();
    run_op(4'd3, 32'd1, 32'd1, 0, -1, 1'b0);
    check("lit_after_reset", bus.result_o, 32'd2);

    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       begin a = 32'h0;                    b = $urandom; end
        1:       begin a = $urandom_range(0, 255);   b = $urandom_range(0, 255); end
        2:       begin a = $urandom;                 b = a; end
        default: begin a = $urandom;                 b = $urandom; end
      endcase
      hold = $urandom_range(0, 3);
      d    = (code == 4'd5) ? int'(W) : 0;
      fk   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, d + hold + 1)) : -1;
      run_op(code, a, b, hold, fk, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
